uvmt_cv32e40s_sl_obi_fifo_ctrl: RTL and testbench

UVMT_CV32E40S_SL_OBI_FIFO_CTRL -- requirements
Module: uvmt_cv32e40s_sl_obi_fifo_ctrl

---
 rtl/uvmt_cv32e40s_sl_obi_fifo_ctrl_if.sv | 29 ++
 rtl/uvmt_cv32e40s_sl_obi_fifo_ctrl.sv | 86 ++++++++
 tb/tb_uvmt_cv32e40s_sl_obi_fifo_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uvmt_cv32e40s_sl_obi_fifo_ctrl_if.sv
// OBI handshake inputs and FIFO-control outputs of the support-logic FIFO controller.
interface uvmt_cv32e40s_sl_obi_fifo_ctrl_if #(
  parameter int FIFO_SIZE = 2
);
  localparam int CW = $clog2(FIFO_SIZE + 1);

  logic          obi_req_i;
  logic          obi_gnt_i;
  logic          obi_rvalid_i;
  logic          add_item_o;
  logic          shift_fifo_o;
  logic [CW-1:0] count_o;
  logic [1:0]    state_o;
  logic          overflow_err_o;
  logic          underflow_err_o;
  logic          timeout_o;

  modport master (
    output obi_req_i, obi_gnt_i, obi_rvalid_i,
    input  add_item_o, shift_fifo_o, count_o, state_o,
           overflow_err_o, underflow_err_o, timeout_o
  );

  modport slave (
    input  obi_req_i, obi_gnt_i, obi_rvalid_i,
    output add_item_o, shift_fifo_o, count_o, state_o,
           overflow_err_o, underflow_err_o, timeout_o
  );
endinterface

// File: rtl/uvmt_cv32e40s_sl_obi_fifo_ctrl.sv
// Tracks outstanding OBI transactions, strobes push/pop of a support-logic FIFO,
// and latches overflow/underflow into an absorbing ERROR state.
module uvmt_cv32e40s_sl_obi_fifo_ctrl #(
  parameter int FIFO_SIZE      = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk_i,
  input logic rst_i,
  uvmt_cv32e40s_sl_obi_fifo_ctrl_if.slave bus
);
  localparam int CW = $clog2(FIFO_SIZE + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2,
    ERROR   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          ovf_q, unf_q, timeout_q;

  logic accept, resp, in_err, ovf_det, unf_det, add, shift;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    accept  = bus.obi_req_i & bus.obi_gnt_i;
    resp    = bus.obi_rvalid_i;
    in_err  = (state_q == ERROR);
    ovf_det = accept & (count_q == CW'(FIFO_SIZE)) & ~resp & ~in_err;
    // A response can never precede its own accept, so a same-cycle accept does not help.
    unf_det = resp & (count_q == '0) & ~in_err;
    add     = accept & ~in_err & ~ovf_det & ~rst_i;
    shift   = resp & (count_q != '0) & ~in_err & ~rst_i;

    count_d = count_q;
    case ({add, shift})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    if (in_err || ovf_det || unf_det) state_d = ERROR;
    else if (count_d == '0)            state_d = EMPTY;
    else if (count_d == CW'(FIFO_SIZE)) state_d = FULL;
    else                               state_d = PARTIAL;

    wait_d = wait_q;
    if (!in_err) begin
      if (resp || count_q == '0)               wait_d = '0;
      else if (wait_q != WW'(TIMEOUT_CYCLES)) wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      wait_q    <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wait_q    <= wait_d;
      ovf_q     <= ovf_q | ovf_det;
      unf_q     <= unf_q | unf_det;
      timeout_q <= (wait_d == WW'(TIMEOUT_CYCLES));
    end
  end

  assign bus.add_item_o      = add;
  assign bus.shift_fifo_o    = shift;
  assign bus.count_o         = count_q;
  assign bus.state_o         = state_q;
  assign bus.overflow_err_o  = ovf_q;
  assign bus.underflow_err_o = unf_q;
  assign bus.timeout_o       = timeout_q;
endmodule

// File: tb/tb_uvmt_cv32e40s_sl_obi_fifo_ctrl.sv
// Scoreboard bench: stimulus pushes expected outputs from a reference model; a monitor pops and compares.
module tb_uvmt_cv32e40s_sl_obi_fifo_ctrl;
  localparam int FS = 2;
  localparam int TO = 4;

  typedef struct {
    bit add;
    bit sh;
    int cnt;
    int st;
    bit ovf;
    bit unf;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uvmt_cv32e40s_sl_obi_fifo_ctrl_if #(.FIFO_SIZE(FS)) bus ();

  uvmt_cv32e40s_sl_obi_fifo_ctrl #(.FIFO_SIZE(FS), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: outstanding-transaction bookkeeping in plain integers.
  bit m_known = 0;
  int m_out   = 0;
  bit m_dead  = 0;
  bit m_ovf   = 0;
  bit m_unf   = 0;
  int m_wait  = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input bit req, input bit gnt, input bit rv, input bit rs);
    exp_t e;
    bit acc, oc, uc;
    @(posedge clk);
    #1;
    bus.obi_req_i    = req;
    bus.obi_gnt_i    = gnt;
    bus.obi_rvalid_i = rv;
    rst              = rs;
    acc = req && gnt;
    oc  = acc && m_out == FS && !rv && !m_dead;
    uc  = rv && m_out == 0 && !m_dead;
    e.add = acc && !m_dead && !oc && !rs;
    e.sh  = rv && m_out > 0 && !m_dead && !rs;
    e.cnt = m_out;
    e.st  = m_dead ? 3 : (m_out == 0 ? 0 : (m_out == FS ? 2 : 1));
    e.ovf = m_ovf;
    e.unf = m_unf;
    e.to  = (m_wait == TO);
    if (m_known) exp_q.push_back(e);
    if (rs) begin
      m_known = 1; m_out = 0; m_dead = 0; m_ovf = 0; m_unf = 0; m_wait = 0;
    end else if (!m_dead) begin
      if (rv || m_out == 0) m_wait = 0;
      else if (m_wait < TO) m_wait++;
      m_out = m_out + int'(e.add) - int'(e.sh);
      if (oc) m_ovf = 1;
      if (uc) m_unf = 1;
      if (oc || uc) m_dead = 1;
    end
  endtask

  // Monitor: the DUT presents a full output vector every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("add_item",     int'(bus.add_item_o),      int'(e.add));
        check("shift_fifo",   int'(bus.shift_fifo_o),    int'(e.sh));
        check("count",        int'(bus.count_o),         e.cnt);
        check("state",        int'(bus.state_o),         e.st);
        check("overflow_err", int'(bus.overflow_err_o),  int'(e.ovf));
        check("underflow_err",int'(bus.underflow_err_o), int'(e.unf));
        check("timeout",      int'(bus.timeout_o),       int'(e.to));
      end
    end
  end

  initial begin
    int guard;
    bus.obi_req_i    = 1'b0;
    bus.obi_gnt_i    = 1'b0;
    bus.obi_rvalid_i = 1'b0;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // Two back-to-back accepts fill, then accept+resp while full.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 0);
    // Accept while full without resp: overflow, then ERROR absorbs traffic.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    // Response with nothing outstanding: underflow.
    cyc(0, 0, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(0, 0, 0, 1);
    // Single outstanding, wait past the timeout, then respond.
    cyc(1, 1, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    // Reset mid-transaction with a nonzero wait counter.
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    // Randomised traffic with occasional resets to leave ERROR.
    for (int i = 0; i < 3000; i++) begin
      bit r, g, v, s;
      r = ($urandom_range(0, 99) < 55);
      g = ($urandom_range(0, 99) < 70);
      v = ($urandom_range(0, 99) < 30);
      s = ($urandom_range(0, 99) < 3);
      cyc(r, g, v, s);
    end
    cyc(0, 0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
